store_fwd_buffer: RTL

STORE_FWD_BUFFER -- requirements
Module: store_fwd_buffer

---
 rtl/store_fwd_buffer_pkg.sv | 12 +
 rtl/store_fwd_match.sv | 35 +++
 rtl/store_fwd_buffer.sv | 99 +++++++++
 3 files changed

// File: rtl/store_fwd_buffer_pkg.sv
// Shared widths and the buffered-store record used by the store forwarding buffer.
package store_fwd_buffer_pkg;

    localparam int SFB_DATA_W = 32;
    localparam int SFB_ADDR_W = 32;

    typedef struct packed {
        logic [SFB_ADDR_W-1:0] addr;
        logic [SFB_DATA_W-1:0] data;
    } sfb_entry_t;

endpackage

// File: rtl/store_fwd_match.sv
// Address match across buffered stores; the youngest valid match (nearest the tail) wins.
module store_fwd_match
    import store_fwd_buffer_pkg::*;
#(
    parameter int DATA_W = SFB_DATA_W,
    parameter int ADDR_W = SFB_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] entry_addr,
    input  logic [DEPTH-1:0][DATA_W-1:0] entry_data,
    input  logic [DEPTH-1:0]             entry_valid,
    input  logic [PTR_W-1:0]             tail_ptr,
    input  logic [ADDR_W-1:0]            ld_addr,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic [PTR_W-1:0] idx;

    // Walk backwards from the slot just behind the tail so the first match found is the youngest.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            idx = tail_ptr - PTR_W'(k);
            if (!hit && entry_valid[idx] && (ld_addr != '0) && (entry_addr[idx] == ld_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_fwd_buffer.sv
// In-order store buffer that drains to data memory and forwards buffered data to loads.
module store_fwd_buffer
    import store_fwd_buffer_pkg::*;
#(
    parameter int DATA_W = SFB_DATA_W,
    parameter int ADDR_W = SFB_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              dm_wr_en,
    output logic [ADDR_W-1:0] dm_wr_addr,
    output logic [DATA_W-1:0] dm_wr_data,
    input  logic              dm_wr_ack,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][ADDR_W-1:0] entry_addr;
    logic [DEPTH-1:0][DATA_W-1:0] entry_data;
    logic [DEPTH-1:0]             entry_valid;
    logic [PTR_W-1:0]             head_ptr;
    logic [PTR_W-1:0]             tail_ptr;
    logic [CNT_W-1:0]             count_q;
    logic                         push;
    logic                         pop;
    logic                         match_hit;
    logic [DATA_W-1:0]            match_data;

    // Readiness depends only on registered occupancy, so a same-cycle drain never frees a full buffer.
    assign st_ready   = (count_q != CNT_W'(DEPTH));
    assign dm_wr_en   = (count_q != '0);
    assign dm_wr_addr = entry_addr[head_ptr];
    assign dm_wr_data = entry_data[head_ptr];
    assign count      = count_q;

    // Stores to address zero complete the handshake but are dropped.
    assign push = st_valid && st_ready && (st_addr != '0);
    assign pop  = dm_wr_en && dm_wr_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr    <= '0;
            tail_ptr    <= '0;
            count_q     <= '0;
            entry_valid <= '0;
        end else begin
            if (pop) begin
                entry_valid[head_ptr] <= 1'b0;
                head_ptr              <= head_ptr + PTR_W'(1);
            end
            if (push) begin
                entry_valid[tail_ptr] <= 1'b1;
                tail_ptr              <= tail_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // Payload storage is qualified by entry_valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr[tail_ptr] <= st_addr;
            entry_data[tail_ptr] <= st_data;
        end
    end

    store_fwd_match #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) u_match (
        .entry_addr (entry_addr),
        .entry_data (entry_data),
        .entry_valid(entry_valid),
        .tail_ptr   (tail_ptr),
        .ld_addr    (ld_addr),
        .hit        (match_hit),
        .data       (match_data)
    );

    assign ld_hit  = ld_valid && match_hit;
    assign ld_data = ld_hit ? match_data : '0;

endmodule
